// File: rtl/prod_sum_accum_pkg.sv
// ----------------------------------------------------------------------------
// prod_sum_accum_pkg
// Shared types and helpers for the prod_sum_accum_seq multiply-accumulate
// controller.
//   state_t     : controller state encoding (IDLE, ACCUM, DONE), 2 bits.
//   usat_limit  : largest unsigned value of a w-bit accumulator (2^w - 1).
//   smax_limit  : largest signed value of a w-bit accumulator (2^(w-1) - 1).
//   smin_limit  : smallest signed value of a w-bit accumulator (-2^(w-1)),
//                 returned in 64-bit two's complement; the caller truncates.
// The limit helpers let the top derive its saturation localparams from its
// own SUM_width parameter rather than from a fixed package constant.
// ----------------------------------------------------------------------------
package prod_sum_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [63:0] usat_limit(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] smax_limit(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] smin_limit(input int w);
      return ~smax_limit(w);
   endfunction

endpackage

// File: rtl/prod_sum_accum_seq_prod_sum.sv
// ----------------------------------------------------------------------------
// prod_sum_accum_seq_prod_sum
// Combinational single-term product-sum, functionally equivalent to a
// DW02_prod_sum1 instance: sum = a*b + c, all modulo 2^SUM_width.
//   a   in  A_width    operand A
//   b   in  B_width    operand B
//   c   in  SUM_width  addend (the accumulator)
//   tc  in  1          1 = two's-complement operands, 0 = unsigned
//   sum out SUM_width  a*b + c
// Extending both operands to SUM_width before multiplying gives the correctly
// sign/zero-extended product in the low SUM_width bits, since
// SUM_width >= A_width + B_width.
// ----------------------------------------------------------------------------
module prod_sum_accum_seq_prod_sum
   import prod_sum_accum_pkg::*;
#(
   parameter int A_width   = 5,
   parameter int B_width   = 5,
   parameter int SUM_width = 11
) (
   input  logic [A_width-1:0]   a,
   input  logic [B_width-1:0]   b,
   input  logic [SUM_width-1:0] c,
   input  logic                 tc,
   output logic [SUM_width-1:0] sum
);

   logic [SUM_width-1:0] a_ext;
   logic [SUM_width-1:0] b_ext;

   // Operand extension and product-sum.
   always_comb begin
      a_ext = {{(SUM_width-A_width){tc & a[A_width-1]}}, a};
      b_ext = {{(SUM_width-B_width){tc & b[B_width-1]}}, b};
      sum   = (a_ext * b_ext) + c;
   end

endmodule

// File: rtl/prod_sum_accum_seq.sv
// ----------------------------------------------------------------------------
// prod_sum_accum_seq
// Sequential multiply-accumulate controller. After start it accepts len
// operand pairs over a valid/ready handshake, accumulating acc <= a*b + acc,
// then offers the final sum on a valid/ready result port.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (aborts any operation)
//   start      in   begin accumulation (honoured only in IDLE)
//   len        in   number of terms, sampled with start
//   tc         in   1 = signed operands, sampled with start
//   in_valid   in   operand pair valid
//   in_ready   out  operand pair accepted (high throughout ACCUM)
//   in_a/in_b  in   operands
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer takes the result
//   out_sum    out  result, 0 outside DONE
//   busy       out  high in any state other than IDLE
// Optional build macro PROD_SUM_ACCUM_SAT_EN: the product-sum runs one bit
// wider and the accumulator saturates at the unsigned/signed range limits
// instead of wrapping.
// All outputs are registered, computed from the next-state values so they
// line up with the state register.
// ----------------------------------------------------------------------------
module prod_sum_accum_seq
   import prod_sum_accum_pkg::*;
#(
   parameter int A_width   = 5,
   parameter int B_width   = 5,
   parameter int SUM_width = 11,
   parameter int LEN_width = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_width-1:0] len,
   input  logic                 tc,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_width-1:0]   in_a,
   input  logic [B_width-1:0]   in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SUM_width-1:0] out_sum,
   output logic                 busy
);

`ifdef PROD_SUM_ACCUM_SAT_EN
   localparam int DP_width = SUM_width + 1;
   localparam logic [SUM_width-1:0] USAT_MAX = SUM_width'(usat_limit(SUM_width));
   localparam logic [SUM_width-1:0] SSAT_MAX = SUM_width'(smax_limit(SUM_width));
   localparam logic [SUM_width-1:0] SSAT_MIN = SUM_width'(smin_limit(SUM_width));
`else
   localparam int DP_width = SUM_width;
`endif

   state_t               state;
   state_t               state_nx;
   logic [SUM_width-1:0] acc;
   logic [SUM_width-1:0] acc_nx;
   logic [LEN_width-1:0] count;
   logic [LEN_width-1:0] count_nx;
   logic                 tc_q;
   logic                 tc_nx;
   logic [DP_width-1:0]  dp_c;
   logic [DP_width-1:0]  dp_sum;
   logic [SUM_width-1:0] term_sum;

   prod_sum_accum_seq_prod_sum #(
      .A_width   (A_width),
      .B_width   (B_width),
      .SUM_width (DP_width)
   ) u_prod_sum (
      .a   (in_a),
      .b   (in_b),
      .c   (dp_c),
      .tc  (tc_q),
      .sum (dp_sum)
   );

`ifdef PROD_SUM_ACCUM_SAT_EN
   // Wide product-sum with clamping. The extra top bit catches unsigned
   // carry-out; in signed mode a disagreement of the top two bits means the
   // true sum left the SUM_width range, and the top bit tells which side.
   always_comb begin
      dp_c = {tc_q & acc[SUM_width-1], acc};
      if (!tc_q) begin
         if (dp_sum[SUM_width]) begin
            term_sum = USAT_MAX;
         end else begin
            term_sum = dp_sum[SUM_width-1:0];
         end
      end else if (dp_sum[SUM_width] != dp_sum[SUM_width-1]) begin
         if (dp_sum[SUM_width]) begin
            term_sum = SSAT_MIN;
         end else begin
            term_sum = SSAT_MAX;
         end
      end else begin
         term_sum = dp_sum[SUM_width-1:0];
      end
   end
`else
   // Wrap-around accumulation: the product-sum is already modulo 2^SUM_width.
   always_comb begin
      dp_c     = acc;
      term_sum = dp_sum;
   end
`endif

   // Next-state, accumulator and term-count logic.
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      count_nx = count;
      tc_nx    = tc_q;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nx   = {SUM_width{1'b0}};
               count_nx = len;
               tc_nx    = tc;
               if (len != {LEN_width{1'b0}}) begin
                  state_nx = ACCUM;
               end else begin
                  state_nx = DONE;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         ACCUM: begin
            // in_ready is high for the whole of ACCUM, so in_valid alone
            // marks an accepted pair.
            if (in_valid) begin
               acc_nx   = term_sum;
               count_nx = count - {{(LEN_width-1){1'b0}}, 1'b1};
               if (count == {{(LEN_width-1){1'b0}}, 1'b1}) begin
                  state_nx = DONE;
               end else begin
                  state_nx = ACCUM;
               end
            end else begin
               state_nx = ACCUM;
            end
         end
         DONE: begin
            // start is deliberately not looked at here, so a start that
            // coincides with the result handshake is dropped.
            if (out_ready) begin
               state_nx = IDLE;
            end else begin
               state_nx = DONE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= {SUM_width{1'b0}};
         count     <= {LEN_width{1'b0}};
         tc_q      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= {SUM_width{1'b0}};
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         count     <= count_nx;
         tc_q      <= tc_nx;
         in_ready  <= (state_nx == ACCUM);
         out_valid <= (state_nx == DONE);
         out_sum   <= (state_nx == DONE) ? acc_nx : {SUM_width{1'b0}};
         busy      <= (state_nx != IDLE);
      end
   end

endmodule

// File: doc/prod_sum_accum_seq.md
Name: prod_sum_accum_seq

Overview:
Sequential multiply-accumulate controller built around one combinational DW02_prod_sum1 datapath instance.
- Accepts a stream of LEN operand pairs (A, B) over a valid/ready handshake.
- Each accepted pair updates the accumulator: acc <= A*B + acc. The accumulator is fed back into the prod-sum C input.
- After the last term, presents the final sum on a valid/ready result port.
- Sits between the operand source (filter taps, dot-product engines) and the result consumer.

Parameters:
- A_width, 5, width of operand A.
- B_width, 5, width of operand B.
- SUM_width, 11, accumulator/result width; must be >= A_width+B_width.
- LEN_width, 8, width of the term-count input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- len  in  LEN_width  number of terms; sampled with start.
- tc  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair.
- in_a  in  A_width  operand A.
- in_b  in  B_width  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SUM_width  accumulated result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state=IDLE, acc=0, count=0, tc_q=0, in_ready=0, out_valid=0, out_sum=0, busy=0. Reset in any state aborts the operation; the partial sum is discarded.
- IDLE: in_ready=0, out_valid=0.
  - start=1 clears acc and latches tc_q<=tc and count<=len.
  - Next state is ACCUM if len!=0, otherwise DONE (result 0).
- ACCUM: in_ready=1.
  - Each cycle with in_valid&in_ready: acc <= prod_sum(in_a, in_b, acc, tc_q) and count decrements.
  - When the accepted term has count==1, next state is DONE.
  - in_valid=0 stalls with no state change.
- DONE: out_valid=1, out_sum=acc, in_ready=0.
  - out_valid&out_ready returns to IDLE in the next cycle. out_valid drops and out_sum returns to 0.
  - out_sum is held stable while out_ready=0.
- Latency: out_valid asserts the cycle after the last term is accepted, or the cycle after start when len=0. Peak throughput is 1 term/cycle.
- start outside IDLE is ignored. A start in the same cycle that DONE completes is also ignored, so start is accepted no earlier than the first IDLE cycle.
- Arithmetic:
  - The product is sign-extended (tc_q=1) or zero-extended (tc_q=0) to SUM_width.
  - The sum is modulo 2^SUM_width; no overflow flag in the base build.
- len=2^LEN_width-1 must work; the count has no wrap-around.

Optional Feature:
- Macro: PROD_SUM_ACCUM_SAT_EN.
- Defined: the sum is computed at SUM_width+1 bits.
  - On overflow, acc clamps to the range limit: unsigned 2^SUM_width-1; signed 2^(SUM_width-1)-1 or -2^(SUM_width-1).
  - Saturation is sticky only through the values themselves: later terms may move acc back inside the range.
- Undefined: wrap-around as described above.

Decomposition:
- Package prod_sum_accum_pkg holds:
  - state enum {IDLE, ACCUM, DONE} (2-bit encoding);
  - localparams for the unsigned/signed saturation limits, as functions of SUM_width.
- One sub-module: a DW02_prod_sum1 instance, A_width/B_width/SUM_width parameters, C driven by acc, TC driven by tc_q.
  - Under PROD_SUM_ACCUM_SAT_EN the instance is sized SUM_width+1, with acc extended on its C input.
- FSM, counter and clamp logic stay in the top module.

Test Plan:
- Unsigned: tc=0, len=3, pairs (3,4),(5,6),(1,1) back-to-back -> out_valid on the cycle after the third accept, out_sum=43.
- Signed: tc=1, len=2, pairs (-1,3),(-2,-2) with one idle cycle between -> out_sum=1; in_ready stays 1 during the gap.
- Overflow: tc=0, len=3, three pairs (31,31).
  - Base build -> out_sum=835.
  - PROD_SUM_ACCUM_SAT_EN -> out_sum=2047.
- Zero length: start with len=0 -> out_valid next cycle, out_sum=0, in_ready never asserted.
- Backpressure/ignore: hold out_ready=0 for 5 cycles in DONE with start pulsed -> out_sum stable, state unchanged; after out_ready=1, busy=0 the next cycle.
- Reset mid-op: assert rst after 2 of 4 terms -> all outputs 0 next cycle; a new start with len=1, pair (2,2) -> out_sum=4.
